// File: rtl/clock_pkg.sv
// Shared types and BCD constants for the clock time-set front end.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] HH_MIN  = 8'h01;
  localparam logic [7:0] HH_MAX  = 8'h12;
  localparam logic [7:0] MM_MAX  = 8'h59;
  localparam logic [7:0] MM_ZERO = 8'h00;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HH   = 2'd1;
  localparam logic [1:0] FIELD_MM   = 2'd2;

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton to clean press pulse: 2-flop sync, debounce, rising-edge
// pulse and optional hold-to-repeat.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            level;
  logic            level_d;
  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rep_cnt;
  logic            rise;
  logic            rep_fire;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Adopt the synced value only after an unbroken run of differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync_p1 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      level  <= sync_p1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign rise     = level & ~level_d;
  // rep_cnt counts cycles since the last press or repeat pulse.
  assign rep_fire = REPEAT_EN && level && !rise && (rep_cnt == RP_W'(REPEAT_CYCLES));

  // Press pulse on the debounced rising edge plus periodic repeats while held.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d <= 1'b0;
      rep_cnt <= '0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      pulse   <= rise | rep_fire;
      if (!level || !REPEAT_EN) begin
        rep_cnt <= '0;
      end else if (rise || rep_fire) begin
        rep_cnt <= RP_W'(1);
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Hour/minute edit front end for the 12-hour BCD clock core: button
// conditioning, edit FSM, BCD increment/sanitize and load handshake.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic       load_valid,
  input  logic       load_ready,
  output logic       editing,
  output logic [1:0] field_sel
);

  state_t     state;
  state_t     state_next;
  logic [7:0] hh_next;
  logic [7:0] mm_next;
  logic       mode_pulse;
  logic       inc_pulse;

  // 12 wraps to 01; low digit 9 carries into the tens digit.
  function automatic logic [7:0] inc_hh(input logic [7:0] hh);
    if (hh == HH_MAX)        return HH_MIN;
    else if (hh[3:0] == 4'd9) return {hh[7:4] + 4'd1, 4'd0};
    else                      return hh + 8'd1;
  endfunction

  // 59 wraps to 00; low digit 9 carries into the tens digit.
  function automatic logic [7:0] inc_mm(input logic [7:0] mm);
    if (mm == MM_MAX)        return MM_ZERO;
    else if (mm[3:0] == 4'd9) return {mm[7:4] + 4'd1, 4'd0};
    else                      return mm + 8'd1;
  endfunction

  // Anything other than a legal 01..12 hour captures as 12.
  function automatic logic [7:0] sanitize_hh(input logic [7:0] hh);
    if ((hh[7:4] == 4'd0 && hh[3:0] != 4'd0 && hh[3:0] <= 4'd9) ||
        (hh[7:4] == 4'd1 && hh[3:0] <= 4'd2))
      return hh;
    else
      return HH_MAX;
  endfunction

  // Anything other than a legal 00..59 minute captures as 00.
  function automatic logic [7:0] sanitize_mm(input logic [7:0] mm);
    if (mm[7:4] <= 4'd5 && mm[3:0] <= 4'd9) return mm;
    else                                    return MM_ZERO;
  endfunction

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (1'b0)
  ) u_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .pulse (mode_pulse)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (1'b1)
  ) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .pulse (inc_pulse)
  );

  // Next state and edited fields; mode outranks inc in the same cycle.
  always_comb begin
    state_next = state;
    hh_next    = set_hh;
    mm_next    = set_mm;
    unique case (state)
      IDLE: begin
        if (mode_pulse) begin
          hh_next    = sanitize_hh(cur_hh);
          mm_next    = sanitize_mm(cur_mm);
          state_next = SET_HH;
        end
      end
      SET_HH: begin
        if (mode_pulse)     state_next = SET_MM;
        else if (inc_pulse) hh_next    = inc_hh(set_hh);
      end
      SET_MM: begin
        if (mode_pulse)     state_next = COMMIT;
        else if (inc_pulse) mm_next    = inc_mm(set_mm);
      end
      COMMIT: begin
        if (load_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Edited time registers; untouched in COMMIT so the offer stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      set_hh <= HH_MAX;
      set_mm <= MM_ZERO;
    end else begin
      set_hh <= hh_next;
      set_mm <= mm_next;
    end
  end

  assign load_valid = (state == COMMIT);
  assign editing    = (state != IDLE);
  assign field_sel  = (state == SET_HH) ? FIELD_HH :
                      (state == SET_MM) ? FIELD_MM : FIELD_NONE;

endmodule

// File: doc/clock_time_setter.md
# clock_time_setter

User time-set front end for the 12-hour BCD clock core. Conditions two raw pushbuttons (mode, increment), runs a hour/minute edit state machine seeded from the running time, and delivers the edited time to the clock core over a valid/ready load handshake. It sits between the board buttons and the clock core's load port.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before a debounced level changes. This is 10 ms at 100 MHz.
- REPEAT_CYCLES, 25_000_000: increment auto-repeat period while held.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw pushbutton, asynchronous, high = pressed.
- btn_inc  in  1  raw pushbutton, asynchronous, high = pressed.
- cur_hh  in  8  current hours from the clock core, packed BCD.
- cur_mm  in  8  current minutes, packed BCD.
- set_hh  out  8  edited hours, packed BCD, 8'h01..8'h12.
- set_mm  out  8  edited minutes, packed BCD, 8'h00..8'h59.
- load_valid  out  1  edited time offered to the core.
- load_ready  in  1  core accepts the load. The core zeroes seconds on acceptance.
- editing  out  1  high in SET_HH, SET_MM and COMMIT.
- field_sel  out  2  field being edited: 0 = none, 1 = hours, 2 = minutes.

## Operation

- **Button conditioning (per button):**
  - 2-flop synchronizer, then a debounce counter. The debounced level takes the synced value only after DEBOUNCE_CYCLES consecutive equal samples. Any mismatch clears the counter.
  - A rising edge of the debounced level produces a one-cycle press pulse.
- **Auto-repeat (inc only):**
  - While the debounced inc stays high, an extra pulse fires every REPEAT_CYCLES after the initial press.
  - Release stops repeat immediately.
- **States:**
  - IDLE: mode pulse captures cur_hh/cur_mm into set_hh/set_mm, then goes to SET_HH.
  - SET_HH: inc pulse advances hours; mode pulse goes to SET_MM.
  - SET_MM: inc pulse advances minutes; mode pulse goes to COMMIT.
  - COMMIT: load_valid=1. On valid && ready, goes to IDLE. Mode and inc pulses are ignored.
- **Hour increment:** 01..09, then 10, 11, 12, then back to 01. Low nibble carries into the high nibble at 9; 12 wraps to 01.
- **Minute increment:** 00..59, then back to 00. Low nibble wraps 9→0 with carry; 59 wraps to 00.
- **Capture sanitizing:**
  - cur_hh that is non-BCD or outside 01..12 loads 8'h12.
  - cur_mm that is non-BCD or above 59 loads 8'h00.
- **Ignored inputs:** inc pulses in IDLE and COMMIT are discarded.
- **Simultaneous mode and inc pulses in one cycle:** mode wins and inc is discarded.
- **Output values while editing:**
  - set_hh and set_mm are held stable while load_valid=1.
  - After acceptance they keep their last values.
- **field_sel:** 1 in SET_HH, 2 in SET_MM, 0 otherwise.

## Timing

- **Reset values:**
  - set_hh=8'h12, set_mm=8'h00, load_valid=0, editing=0, field_sel=0.
  - State IDLE.
  - Synchronizers, debounced levels and all counters at 0 (unpressed).
- **Press latency:** 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 edge cycle from a stable raw transition to the pulse.
- **FSM and outputs:** the state and set_* registers update on the edge after the pulse cycle.
- **load_valid:** asserts on the edge after the third mode pulse. It deasserts on the edge after the first cycle with load_ready=1; editing falls on the same edge.
- **load_ready:** may be high before load_valid. It is sampled only in COMMIT.
- **Reset mid-operation:** reset in any state, including COMMIT with load_valid=1, forces all reset values on the next edge. No load is completed.
- **Repeat counter:** restarts from 0 on each fresh press.

## Structure

- **Shared package clock_pkg holds:**
  - state enum (IDLE, SET_HH, SET_MM, COMMIT);
  - BCD constants HH_MIN=8'h01, HH_MAX=8'h12, MM_MAX=8'h59, MM_ZERO=8'h00;
  - field_sel encodings.
- **Sub-module button_conditioner:**
  - Contents: synchronizer, debounce, edge pulse, and auto-repeat enabled by a parameter.
  - Instantiated twice: repeat disabled for mode, enabled for inc.
- **Top level:** the FSM and the BCD increment/sanitize logic.

## Test plan

All scenarios run with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
1. **Reset:** assert reset for 2 cycles → set_hh=8'h12, set_mm=8'h00, load_valid=0, editing=0, field_sel=0.
2. **Debounce:**
   - btn_mode toggling every 2 cycles for 20 cycles, then low → no state change.
   - Then high for 10 cycles → exactly one transition to SET_HH; editing=1, field_sel=1.
3. **Wrap and handshake (cur_hh=8'h11, cur_mm=8'h58):**
   - Mode, then inc×2 → set_hh 8'h12, then 8'h01.
   - Mode, then inc×2 → set_mm 8'h59, then 8'h00.
   - Mode → load_valid=1 with 01/00.
   - load_ready low for 5 cycles → valid and values held.
   - load_ready high → load_valid=0 and editing=0 on the next edge.
4. **Auto-repeat:** in SET_MM from 8'h00, hold btn_inc long enough for the press plus 3 repeats → set_mm=8'h04. Release → no further change.
5. **Sanitize and ignored inputs:**
   - cur_hh=8'h1A, cur_mm=8'h75 at capture → set_hh=8'h12, set_mm=8'h00.
   - Simultaneous mode+inc pulse in SET_HH → state SET_MM, set_hh unchanged.
6. **Reset in COMMIT:** reset with load_valid=1 and load_ready=0 → load_valid=0 and state IDLE on the next edge; a later load_ready=1 has no effect.
